// File: rtl/mem_arbiter.sv
// Single-port access controller for the unified instruction/data RAM.
// Arbitrates fetch vs load/store with a bounded-starvation rule; IDLE -> ISSUE -> RESP.
module mem_arbiter #(
  parameter int AW           = 16,
  parameter int STARVE_LIMIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_data,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_en,
  output logic [1:0]  mem_rw,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_pc,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  input  logic [31:0] mem_fetch,
  output logic        busy
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_starve_cnt;
  logic            r_grant_d;
  logic            r_we;
  logic            r_err;

  logic            w_if_oor;
  logic            w_d_oor;
  logic            w_starved;
  logic            w_grant_d;

  assign w_if_oor  = (if_addr >> AW) != 32'd0;
  assign w_d_oor   = (d_addr >> AW) != 32'd0;
  assign w_starved = (r_starve_cnt == CW'(STARVE_LIMIT));
  // Data wins a tie unless fetch has already lost STARVE_LIMIT times in a row.
  assign w_grant_d = d_req && !(if_req && w_starved);

  // Arbitration FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_starve_cnt <= '0;
      r_grant_d    <= 1'b0;
      r_we         <= 1'b0;
      r_err        <= 1'b0;
      if_ack       <= 1'b0;
      if_data      <= 32'd0;
      if_err       <= 1'b0;
      d_ack        <= 1'b0;
      d_rdata      <= 32'd0;
      d_err        <= 1'b0;
      mem_en       <= 1'b0;
      mem_rw       <= 2'b00;
      mem_addr     <= 32'd0;
      mem_pc       <= 32'd0;
      mem_din      <= 32'd0;
      busy         <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (if_req || d_req) begin
            r_state <= S_ISSUE;
            busy    <= 1'b1;
            if (w_grant_d) begin
              r_grant_d    <= 1'b1;
              r_we         <= d_we;
              r_err        <= w_d_oor;
              r_starve_cnt <= if_req ? (r_starve_cnt + CW'(1)) : '0;
              // Out-of-range accesses never touch the RAM bus.
              if (!w_d_oor) begin
                mem_en   <= 1'b1;
                mem_rw   <= d_we ? 2'b10 : 2'b01;
                mem_addr <= d_addr;
                if (d_we) begin
                  mem_din <= d_wdata;
                end
              end
            end else begin
              r_grant_d    <= 1'b0;
              r_we         <= 1'b0;
              r_err        <= w_if_oor;
              r_starve_cnt <= '0;
              if (!w_if_oor) begin
                mem_en <= 1'b1;
                mem_rw <= 2'b00;
                mem_pc <= if_addr;
              end
            end
          end
        end
        S_ISSUE: begin
          r_state <= S_RESP;
          mem_en  <= 1'b0;
          mem_rw  <= 2'b00;
          if (r_grant_d) begin
            d_ack <= 1'b1;
            d_err <= r_err;
            if (!r_we) begin
              d_rdata <= r_err ? 32'd0 : mem_dout;
            end
          end else begin
            if_ack  <= 1'b1;
            if_err  <= r_err;
            if_data <= r_err ? 32'd0 : mem_fetch;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          if_ack  <= 1'b0;
          if_err  <= 1'b0;
          d_ack   <= 1'b0;
          d_err   <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          mem_en  <= 1'b0;
          mem_rw  <= 2'b00;
          if_ack  <= 1'b0;
          if_err  <= 1'b0;
          d_ack   <= 1'b0;
          d_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port access controller for the unified 64K x 32 instruction/data RAM.
- Arbitrates between the fetch unit (instruction port) and the load/store unit (data port).
- Drives the RAM's enable, rw, addr, pcin and din inputs. Registers its dout/fetch results back to the winning requester with a one-cycle ack pulse.
- Sits between the core's fetch/LSU stages and the RAM; the core never drives the RAM directly.

Parameters:
- AW, 16, RAM word-address width; a valid address is below 1<<AW.
- STARVE_LIMIT, 2, consecutive data grants allowed while a fetch is pending before fetch is forced to win.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held high with if_addr stable until if_ack
- if_addr  in  32  fetch word address (PC)
- if_ack  out  1  one-cycle pulse: fetch complete
- if_data  out  32  fetched instruction; valid with if_ack, held until next fetch ack
- if_err  out  1  with if_ack: address out of range
- d_req  in  1  data request; held high with d_we/d_addr/d_wdata stable until d_ack
- d_we  in  1  1=write, 0=read
- d_addr  in  32  data word address
- d_wdata  in  32  write data
- d_ack  out  1  one-cycle pulse: data access complete
- d_rdata  out  32  read data; valid with d_ack on reads, held otherwise
- d_err  out  1  with d_ack: address out of range
- mem_en  out  1  RAM enable
- mem_rw  out  2  RAM op: 00=fetch via pcin, 01=read, 10=write
- mem_addr  out  32  RAM data address
- mem_pc  out  32  RAM fetch address (pcin)
- mem_din  out  32  RAM write data
- mem_dout  in  32  RAM read data
- mem_fetch  in  32  RAM fetch data
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset: all outputs 0, mem_rw=00, state IDLE, starvation counter 0. Reset overrides every state.
- Reset mid-operation:
  - Any transaction in flight is abandoned and no ack is issued.
  - A write already presented in ISSUE may have reached the RAM; this is permitted.
- States: IDLE -> ISSUE -> RESP -> IDLE. All outputs are registered.
- IDLE, arbitration on each edge:
  - Neither requester asserted: stay in IDLE.
  - Only one requester: it wins.
  - Both requesters: data wins, unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
  - On a data grant, starve_cnt increments if if_req is also high; otherwise it clears.
  - On a fetch grant, starve_cnt clears.
  - The grant, address and write data are latched on that edge.
- Range check at grant: if the address is at or above 1<<AW, mark error, skip RAM access (mem_en stays 0 in ISSUE) and go to ISSUE anyway.
- ISSUE, one cycle, mem_en=1 unless error:
  - fetch: mem_rw=00, mem_pc=latched addr
  - data read: mem_rw=01, mem_addr=addr
  - data write: mem_rw=10, mem_addr=addr, mem_din=wdata
  - At the end of ISSUE, capture mem_fetch into if_data or mem_dout into d_rdata. Writes leave d_rdata unchanged.
  - Error reads capture 0.
  - Transition to RESP.
- RESP, one cycle:
  - mem_en=0, mem_rw=00.
  - Pulse the winner's ack; its err reflects the range check.
  - Requests are not sampled in RESP; the requester drops or re-asserts req for its next access.
  - Next state is IDLE.
- Latency: req seen high at edge N gives ack high in cycle N+2. Throughput is one access per 3 cycles.
- Outside ISSUE: mem_en=0, mem_rw=00, mem_addr/mem_pc/mem_din hold their last values.
- Ack and err are never high outside RESP. if_ack and d_ack are never high in the same cycle.
- A requester dropping req before ack is a protocol violation; the block still completes and acks the latched transaction.

Test Plan:
- Reset then fetch:
  - Stimulus: preload RAM[0x10]=0xDEADBEEF; if_req=1, if_addr=0x10.
  - Required: mem_rw=00, mem_pc=0x10, mem_en=1 for one cycle; if_ack pulses 2 cycles after the request; if_data=0xDEADBEEF; if_err=0.
- Write then read back:
  - Stimulus: d_req, d_we=1, d_addr=0x20, d_wdata=0x12345678 until ack; then a read of 0x20.
  - Required: write presents mem_rw=10, mem_din=0x12345678; read acks with d_rdata=0x12345678.
- Simultaneous requests held continuously:
  - Required grant order: data, data, fetch, data, data, fetch; starve_cnt never exceeds 2; no cycle has both acks.
- Out of range:
  - Stimulus: d_addr=0x10000, read.
  - Required: mem_en stays 0 throughout; d_ack with d_err=1 and d_rdata=0; a following in-range access has d_err=0.
- Reset asserted during ISSUE of a fetch:
  - Required: no if_ack; the next cycle shows all outputs 0 and busy=0; a new request then completes normally.
- Idle bus:
  - Stimulus: no requests for 10 cycles.
  - Required: mem_en=0, mem_rw=00, busy=0, no acks.
